// File: rtl/adc_ctrl_pkg.sv
// Shared state encoding, trigger levels and sizing helper for the ADC sample controller.
package adc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_TRIG    = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_CAPTURE = 3'd4
  } adc_state_t;

  localparam logic ADC_TRIG_ON  = 1'b1;
  localparam logic ADC_TRIG_OFF = 1'b0;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// Synchronous result FIFO; a push into a full FIFO is accepted only when a pop frees a slot
// in the same cycle, otherwise it is reported on o_drop.
module adc_sample_fifo
  import adc_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_push,
  input  logic [DATA_WIDTH-1:0]       i_push_data,
  input  logic                        i_pop,
  output logic [DATA_WIDTH-1:0]       o_head,
  output logic                        o_empty,
  output logic [$clog2(FIFO_DEPTH):0] o_count,
  output logic                        o_drop
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = fifo_cnt_w(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_full;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~w_full | w_do_pop);
  assign o_drop    = i_push & ~w_do_push;
  assign o_count   = r_count;
  // Head reads as zero when empty so stale storage never leaks after reset.
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/adc_sample_ctrl.sv
// Self-timed ADC acquisition: periodic trigger, settle wait, capture, 2^AVG_LOG2 averaging,
// and queuing of each average into the result FIFO.
//
//   state      | meaning
//   IDLE       | stopped; timer preloaded with period
//   WAIT       | period down-count before the next conversion
//   TRIG       | adc_trigger asserted for this single cycle
//   SETTLE     | settle down-count after the trigger
//   CAPTURE    | measurement sampled at the end of this cycle
module adc_sample_ctrl
  import adc_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 8,
  parameter int AVG_LOG2      = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [DATA_WIDTH-1:0]       period,
  output logic [DATA_WIDTH-1:0]       adc_trigger,
  input  logic [DATA_WIDTH-1:0]       adc_measurement,
  input  logic                        rd_en,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        rd_valid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  input  logic                        clear_overflow
);

  localparam int ACC_W = DATA_WIDTH + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST    = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [DATA_WIDTH-1:0] SETTLE_LOAD = DATA_WIDTH'(SETTLE_CYCLES - 1);

  adc_state_t            r_state;
  adc_state_t            w_state_nxt;
  logic [DATA_WIDTH-1:0] r_timer;
  logic [DATA_WIDTH-1:0] w_period_load;
  logic                  w_timer_zero;
  logic [ACC_W-1:0]      r_acc;
  logic [CNT_W-1:0]      r_cnt;
  logic [ACC_W-1:0]      w_sum;
  logic                  w_capture;
  logic                  w_last;
  logic                  w_push;
  logic [DATA_WIDTH-1:0] w_push_data;
  logic                  w_fifo_empty;
  logic                  w_drop;
  logic                  r_overflow;

  // A zero period behaves as one idle cycle.
  assign w_period_load = (period == '0) ? '0 : period - DATA_WIDTH'(1);
  assign w_timer_zero  = (r_timer == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    w_state_nxt = ST_WAIT;
        ST_WAIT:    if (w_timer_zero) w_state_nxt = ST_TRIG;
        ST_TRIG:    w_state_nxt = ST_SETTLE;
        ST_SETTLE:  if (w_timer_zero) w_state_nxt = ST_CAPTURE;
        ST_CAPTURE: begin
          w_state_nxt = ST_WAIT;
          w_capture   = 1'b1;
        end
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // One down-counter serves both the period wait and the settle wait.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_CAPTURE: r_timer <= w_period_load;
        ST_TRIG:             r_timer <= SETTLE_LOAD;
        default:             if (!w_timer_zero) r_timer <= r_timer - DATA_WIDTH'(1);
      endcase
    end
  end

  assign w_sum       = r_acc + ACC_W'(adc_measurement);
  assign w_last      = (r_cnt == CNT_LAST);
  assign w_push      = w_capture & w_last;
  assign w_push_data = DATA_WIDTH'(w_sum >> AVG_LOG2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (!enable) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_capture) begin
      if (w_last) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // A drop in the same cycle as clear_overflow leaves the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               r_overflow <= 1'b0;
    else if (w_drop)         r_overflow <= 1'b1;
    else if (clear_overflow) r_overflow <= 1'b0;
  end

  adc_sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (rd_en),
    .o_head      (rd_data),
    .o_empty     (w_fifo_empty),
    .o_count     (fifo_count),
    .o_drop      (w_drop)
  );

  assign adc_trigger = (r_state == ST_TRIG) ? DATA_WIDTH'(ADC_TRIG_ON) : DATA_WIDTH'(ADC_TRIG_OFF);
  assign rd_valid    = ~w_fifo_empty;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Directed scoreboard bench for adc_sample_ctrl (default instance plus an AVG_LOG2=0 instance).
module tb_adc_sample_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable, rd_en, clear_overflow;
  logic [31:0] period, adc_measurement, adc_trigger, rd_data;
  logic        rd_valid, overflow;
  logic [3:0]  fifo_count;

  logic        en0, rd_en0, clr0;
  logic [31:0] period0, meas0, trig0, rd_data0;
  logic        rd_valid0, overflow0;
  logic [3:0]  fifo_count0;

  adc_sample_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable), .period(period),
    .adc_trigger(adc_trigger), .adc_measurement(adc_measurement),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_count(fifo_count), .overflow(overflow), .clear_overflow(clear_overflow)
  );

  adc_sample_ctrl #(.AVG_LOG2(0)) dut0 (
    .clk(clk), .reset(reset), .enable(en0), .period(period0),
    .adc_trigger(trig0), .adc_measurement(meas0),
    .rd_en(rd_en0), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .fifo_count(fifo_count0), .overflow(overflow0), .clear_overflow(clr0)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_q[$];
  logic        exp_ovf;
  logic [33:0] m_acc;
  int          m_cnt;
  int          trig_cyc, prev_trig_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fifo(input string tag);
    chk({tag, "_count"}, 32'(fifo_count), 32'(exp_q.size()));
    chk({tag, "_valid"}, 32'(rd_valid), 32'(exp_q.size() != 0));
    chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
  endtask

  task automatic chk_interval(input int exp);
    chk("trig_interval", 32'(trig_cyc - prev_trig_cyc), 32'(exp));
  endtask

  task automatic wait_trig();
    int n = 0;
    @(negedge clk);
    while (adc_trigger === 32'd0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("trig_seen", 32'(n < 200), 32'd1);
    chk("trig_value", adc_trigger, 32'd1);
    prev_trig_cyc = trig_cyc;
    trig_cyc      = cyc;
  endtask

  // Entered at the negedge inside TRIG; returns at the negedge after the capture edge.
  task automatic finish_conv(input logic [31:0] m, input bit pop, input bit clr);
    logic [31:0] res;
    bit          dropped;
    adc_measurement = m;
    @(negedge clk);
    chk("trig_one_cycle", adc_trigger, 32'd0);
    repeat (2) @(negedge clk);
    if (pop) begin
      chk("cap_pop_valid", 32'(rd_valid), 32'd1);
      if (exp_q.size() > 0) chk("cap_pop_data", rd_data, exp_q.pop_front());
      rd_en = 1'b1;
    end
    if (clr) clear_overflow = 1'b1;
    @(negedge clk);
    rd_en          = 1'b0;
    clear_overflow = 1'b0;
    m_acc   = m_acc + 34'(m);
    m_cnt++;
    dropped = 1'b0;
    if (m_cnt == 4) begin
      res = m_acc[33:2];
      if (exp_q.size() >= 8) begin
        exp_ovf = 1'b1;
        dropped = 1'b1;
      end else begin
        exp_q.push_back(res);
      end
      m_acc = '0;
      m_cnt = 0;
    end
    if (clr && !dropped) exp_ovf = 1'b0;
  endtask

  task automatic do_conv(input logic [31:0] m, input bit pop = 1'b0, input bit clr = 1'b0);
    wait_trig();
    finish_conv(m, pop, clr);
  endtask

  task automatic rd_pop();
    logic [31:0] e;
    e = exp_q.pop_front();
    chk("pop_valid", 32'(rd_valid), 32'd1);
    chk("pop_data", rd_data, e);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic drain_all(input string tag);
    int g = 0;
    while (exp_q.size() > 0 && g < 16) begin
      rd_pop();
      g++;
    end
    chk_fifo(tag);
  endtask

  task automatic wait_trig0();
    int n = 0;
    @(negedge clk);
    while (trig0 === 32'd0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("trig0_seen", 32'(n < 100), 32'd1);
  endtask

  initial begin
    int n;
    reset = 1'b1; enable = 1'b0; period = 32'd4; adc_measurement = '0;
    rd_en = 1'b0; clear_overflow = 1'b0;
    en0 = 1'b0; rd_en0 = 1'b0; clr0 = 1'b0; period0 = 32'd2; meas0 = 32'hDEADBEEF;
    exp_ovf = 1'b0; m_acc = '0; m_cnt = 0; trig_cyc = 0; prev_trig_cyc = 0;
    repeat (3) @(negedge clk);
    chk("rst_trig", adc_trigger, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk_fifo("rst");
    reset = 1'b0;
    @(negedge clk);

    // No averaging: every capture becomes a result.
    en0 = 1'b1;
    wait_trig0();
    repeat (4) @(negedge clk);
    chk("avg0_count", 32'(fifo_count0), 32'd1);
    chk("avg0_data", rd_data0, 32'hDEADBEEF);
    rd_en0 = 1'b1;
    @(negedge clk);
    rd_en0 = 1'b0;
    chk("avg0_popped", 32'(fifo_count0), 32'd0);
    wait_trig0();
    repeat (4) @(negedge clk);
    chk("avg0_count2", 32'(fifo_count0), 32'd1);
    chk("avg0_data2", rd_data0, 32'hDEADBEEF);
    en0 = 1'b0;

    // Basic averaging and 8-cycle conversion interval.
    enable = 1'b1;
    do_conv(32'd10);
    do_conv(32'd20); chk_interval(8);
    do_conv(32'd30); chk_interval(8);
    do_conv(32'd40); chk_interval(8);
    chk("avg_valid", 32'(rd_valid), 32'd1);
    chk("avg_data", rd_data, 32'd25);
    chk("avg_count", 32'(fifo_count), 32'd1);

    // Truncating average: 7 >> 2 = 1.
    do_conv(32'd1); do_conv(32'd2); do_conv(32'd2); do_conv(32'd2);
    chk_fifo("trunc");
    enable = 1'b0;
    @(negedge clk);
    drain_all("drain1");

    // Pop while empty is ignored.
    rd_en = 1'b1;
    repeat (2) @(negedge clk);
    rd_en = 1'b0;
    chk("empty_pop_data", rd_data, 32'd0);
    chk_fifo("empty_pop");

    // Disable mid-group discards the partial sum.
    enable = 1'b1;
    do_conv(32'd100); do_conv(32'd100);
    enable = 1'b0;
    m_acc = '0; m_cnt = 0;
    repeat (3) @(negedge clk);
    chk("dis_trig", adc_trigger, 32'd0);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) do_conv(32'd4);
    chk("dis_result", rd_data, 32'd4);
    chk_fifo("dis");
    enable = 1'b0;
    @(negedge clk);
    drain_all("drain2");

    // period = 0 behaves as 1: 5-cycle interval.
    period = 32'd0;
    enable = 1'b1;
    do_conv(32'd7);
    for (int i = 0; i < 3; i++) begin
      do_conv(32'd7);
      chk_interval(5);
    end
    enable = 1'b0;
    @(negedge clk);
    drain_all("drain3");
    period = 32'd4;

    // Overflow, clear, set-wins, and pop on the full-push cycle.
    enable = 1'b1;
    for (int i = 0; i < 36; i++) do_conv(32'd5);
    chk("ovf_count", 32'(fifo_count), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk_fifo("ovf");
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    exp_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < 3; i++) do_conv(32'd5);
    do_conv(32'd5, 1'b0, 1'b1);
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    exp_ovf = 1'b0;
    for (int i = 0; i < 3; i++) do_conv(32'd5);
    do_conv(32'd5, 1'b1, 1'b0);
    chk("full_pp_count", 32'(fifo_count), 32'd8);
    chk("full_pp_ovf", 32'(overflow), 32'd0);
    enable = 1'b0;
    @(negedge clk);
    drain_all("drain4");

    // Push and pop together at count 3 keeps count and order.
    enable = 1'b1;
    for (int i = 0; i < 4; i++) do_conv(32'd8);
    for (int i = 0; i < 4; i++) do_conv(32'd12);
    for (int i = 0; i < 4; i++) do_conv(32'd16);
    chk("pp_pre_count", 32'(fifo_count), 32'd3);
    for (int i = 0; i < 3; i++) do_conv(32'd20);
    do_conv(32'd20, 1'b1, 1'b0);
    chk("pp_count", 32'(fifo_count), 32'd3);
    chk("pp_head", rd_data, 32'd12);
    enable = 1'b0;
    @(negedge clk);
    drain_all("drain5");

    // Async reset during SETTLE with three entries held.
    enable = 1'b1;
    for (int g = 1; g <= 3; g++)
      for (int i = 0; i < 4; i++) do_conv(32'(g));
    chk("rst2_pre_count", 32'(fifo_count), 32'd3);
    wait_trig();
    adc_measurement = 32'd9;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst2_trig", adc_trigger, 32'd0);
    chk("rst2_count", 32'(fifo_count), 32'd0);
    chk("rst2_valid", 32'(rd_valid), 32'd0);
    chk("rst2_ovf", 32'(overflow), 32'd0);
    exp_q.delete();
    m_acc = '0; m_cnt = 0; exp_ovf = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (adc_trigger === 32'd0 && n < 50);
    chk("rst2_first_trig", 32'(n), 32'd5);
    trig_cyc = cyc;
    finish_conv(32'd6, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) do_conv(32'd6);
    chk("rst2_result", rd_data, 32'd6);
    chk_fifo("rst2_post");
    enable = 1'b0;
    @(negedge clk);
    drain_all("drain6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
